powerup_ctrl: RTL and testbench



---
 rtl/powerup_pkg.sv | 24 ++
 rtl/powerup_ctrl_if.sv | 27 ++
 rtl/powerup_ctrl_box_overlap.sv | 18 +
 rtl/powerup_ctrl.sv | 134 +++++++++++++
 tb/tb_powerup_ctrl.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/powerup_pkg.sv
// rtl/powerup_pkg.sv - shared state encoding, widths and default constants for powerup_ctrl
package powerup_pkg;

   localparam int ROW_W = 9;
   localparam int COL_W = 10;
   localparam int CNT_W = 8;
   localparam int BOX_W = 11;

   localparam int DEF_ITEM_ROW        = 200;
   localparam int DEF_ITEM_COL        = 300;
   localparam int DEF_ITEM_SIZE       = 20;
   localparam int DEF_PLAYER_SIZE     = 40;
   localparam int DEF_SPAWN_FRAMES    = 240;
   localparam int DEF_ACTIVE_FRAMES   = 180;
   localparam int DEF_COOLDOWN_FRAMES = 60;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SPAWNED  = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_COOLDOWN = 2'd3
   } state_e;

endpackage

// File: rtl/powerup_ctrl_if.sv
// rtl/powerup_ctrl_if.sv - game-logic and scan-position bus for powerup_ctrl
interface powerup_ctrl_if;
   import powerup_pkg::*;

   logic                   frame_tick;
   logic                   spawn_req;
   logic [ROW_W-1:0]       player_row;
   logic [COL_W-1:0]       player_col;
   logic [ROW_W-1:0]       row;
   logic [COL_W-1:0]       col;
   logic                   lightning_powerup;
   logic                   item_visible;
   logic                   item_pixel;
   logic                   pickup;
   logic [CNT_W-1:0]       frames_left;

   modport master (
      output frame_tick, spawn_req, player_row, player_col, row, col,
      input  lightning_powerup, item_visible, item_pixel, pickup, frames_left
   );

   modport slave (
      input  frame_tick, spawn_req, player_row, player_col, row, col,
      output lightning_powerup, item_visible, item_pixel, pickup, frames_left
   );

endinterface

// File: rtl/powerup_ctrl_box_overlap.sv
// rtl/powerup_ctrl_box_overlap.sv - combinational axis-aligned box overlap test
module box_overlap
   import powerup_pkg::*;
(
   input  logic [BOX_W-1:0] a_row,
   input  logic [BOX_W-1:0] a_col,
   input  logic [BOX_W-1:0] a_size,
   input  logic [BOX_W-1:0] b_row,
   input  logic [BOX_W-1:0] b_col,
   input  logic [BOX_W-1:0] b_size,
   output logic             hit
);

   // Strict comparisons so boxes that only share an edge do not overlap.
   assign hit = (a_row < b_row + b_size) && (a_row + a_size > b_row) &&
                (a_col < b_col + b_size) && (a_col + a_size > b_col);

endmodule

// File: rtl/powerup_ctrl.sv
// rtl/powerup_ctrl.sv - lightning power-up item spawn, pickup, active and cooldown sequencer
module powerup_ctrl
   import powerup_pkg::*;
#(
   parameter int ITEM_ROW        = DEF_ITEM_ROW,
   parameter int ITEM_COL        = DEF_ITEM_COL,
   parameter int ITEM_SIZE       = DEF_ITEM_SIZE,
   parameter int PLAYER_SIZE     = DEF_PLAYER_SIZE,
   parameter int SPAWN_FRAMES    = DEF_SPAWN_FRAMES,
   parameter int ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
   parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
)(
   input  logic           clk,
   input  logic           resetn,
   powerup_ctrl_if.slave  bus
);

   localparam logic [BOX_W-1:0] I_ROW  = BOX_W'(ITEM_ROW);
   localparam logic [BOX_W-1:0] I_COL  = BOX_W'(ITEM_COL);
   localparam logic [BOX_W-1:0] I_SIZE = BOX_W'(ITEM_SIZE);
   localparam logic [BOX_W-1:0] P_SIZE = BOX_W'(PLAYER_SIZE);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lightning_q, lightning_d;
   logic             item_vis_q, item_vis_d;
   logic             item_pixel_q, item_pixel_d;
   logic             pickup_q, pickup_d;
   logic             player_hit;
   logic             scan_hit;

   box_overlap u_player_hit (
      .a_row  (BOX_W'(bus.player_row)),
      .a_col  (BOX_W'(bus.player_col)),
      .a_size (P_SIZE),
      .b_row  (I_ROW),
      .b_col  (I_COL),
      .b_size (I_SIZE),
      .hit    (player_hit)
   );

   box_overlap u_scan_hit (
      .a_row  (BOX_W'(bus.row)),
      .a_col  (BOX_W'(bus.col)),
      .a_size (BOX_W'(1)),
      .b_row  (I_ROW),
      .b_col  (I_COL),
      .b_size (I_SIZE),
      .hit    (scan_hit)
   );

   // Next state, counter and registered outputs; a hit outranks an expiring tick.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pickup_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.spawn_req) begin
               state_d = ST_SPAWNED;
               cnt_d   = CNT_W'(SPAWN_FRAMES);
            end
         end
         ST_SPAWNED: begin
            if (player_hit) begin
               state_d  = ST_ACTIVE;
               cnt_d    = CNT_W'(ACTIVE_FRAMES);
               pickup_d = 1'b1;
            end else if (bus.frame_tick) begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         ST_ACTIVE: begin
            if (bus.frame_tick) begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_COOLDOWN;
                  cnt_d   = CNT_W'(COOLDOWN_FRAMES);
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         ST_COOLDOWN: begin
            if (bus.frame_tick) begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      lightning_d  = (state_d == ST_ACTIVE);
      item_vis_d   = (state_d == ST_SPAWNED);
      item_pixel_d = (state_q == ST_SPAWNED) && scan_hit;
   end

   // State and output registers; async reset clears the power-up enable immediately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         lightning_q  <= 1'b0;
         item_vis_q   <= 1'b0;
         item_pixel_q <= 1'b0;
         pickup_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lightning_q  <= lightning_d;
         item_vis_q   <= item_vis_d;
         item_pixel_q <= item_pixel_d;
         pickup_q     <= pickup_d;
      end
   end

   assign bus.lightning_powerup = lightning_q;
   assign bus.item_visible      = item_vis_q;
   assign bus.item_pixel        = item_pixel_q;
   assign bus.pickup            = pickup_q;
   assign bus.frames_left       = cnt_q;

endmodule

// File: tb/tb_powerup_ctrl.sv
// tb/tb_powerup_ctrl.sv - directed self-checking bench for powerup_ctrl
module tb_powerup_ctrl;

   logic clk;
   logic resetn;
   int   n_checks;
   int   n_fail;

   powerup_ctrl_if bus ();

   powerup_ctrl dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      bus.frame_tick = 1'b1;
      repeat (n) step();
      bus.frame_tick = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      resetn   = 1'b0;
      bus.frame_tick = 1'b0;
      bus.spawn_req  = 1'b0;
      bus.player_row = 9'd0;
      bus.player_col = 10'd0;
      bus.row        = 9'd0;
      bus.col        = 10'd0;
      repeat (3) step();
      check("rst_lightning", 32'(bus.lightning_powerup), 0);
      check("rst_visible",   32'(bus.item_visible), 0);
      check("rst_pixel",     32'(bus.item_pixel), 0);
      check("rst_pickup",    32'(bus.pickup), 0);
      check("rst_frames",    32'(bus.frames_left), 0);
      resetn = 1'b1;
      step();
      check("idle_frames", 32'(bus.frames_left), 0);

      // Spawn, then player whose right edge only touches the item's left column.
      bus.spawn_req = 1'b1;
      step();
      bus.spawn_req = 1'b0;
      check("spawn_visible", 32'(bus.item_visible), 1);
      check("spawn_frames",  32'(bus.frames_left), 240);
      bus.player_row = 9'd190;
      bus.player_col = 10'd260;
      bus.row = 9'd205;
      bus.col = 10'd305;
      step();
      check("touch_no_pickup", 32'(bus.pickup), 0);
      check("touch_no_active", 32'(bus.lightning_powerup), 0);
      check("pixel_inside",    32'(bus.item_pixel), 1);
      bus.row = 9'd220;
      step();
      check("pixel_row_edge", 32'(bus.item_pixel), 0);
      ticks(239);
      check("spawn_last_frame", 32'(bus.frames_left), 1);
      check("spawn_still_vis",  32'(bus.item_visible), 1);
      ticks(1);
      check("expire_visible", 32'(bus.item_visible), 0);
      check("expire_frames",  32'(bus.frames_left), 0);
      bus.row = 9'd205;
      step();
      check("pixel_idle", 32'(bus.item_pixel), 0);

      // Spawn and pick up.
      bus.spawn_req = 1'b1;
      step();
      bus.spawn_req = 1'b0;
      check("spawn2_frames", 32'(bus.frames_left), 240);
      bus.player_col = 10'd290;
      step();
      check("pickup_pulse",     32'(bus.pickup), 1);
      check("pickup_lightning", 32'(bus.lightning_powerup), 1);
      check("pickup_frames",    32'(bus.frames_left), 180);
      check("pickup_invisible", 32'(bus.item_visible), 0);
      step();
      check("pickup_one_cycle", 32'(bus.pickup), 0);
      ticks(179);
      check("active_last",     32'(bus.frames_left), 1);
      check("active_still_on", 32'(bus.lightning_powerup), 1);
      ticks(1);
      check("cooldown_off",    32'(bus.lightning_powerup), 0);
      check("cooldown_frames", 32'(bus.frames_left), 60);
      bus.spawn_req  = 1'b1;
      bus.player_row = 9'd0;
      bus.player_col = 10'd0;
      ticks(59);
      check("cooldown_ignores_spawn", 32'(bus.item_visible), 0);
      check("cooldown_last",          32'(bus.frames_left), 1);
      ticks(1);
      check("cooldown_done_frames", 32'(bus.frames_left), 0);
      check("cooldown_done_vis",    32'(bus.item_visible), 0);
      step();
      bus.spawn_req = 1'b0;
      check("respawn_visible", 32'(bus.item_visible), 1);
      check("respawn_frames",  32'(bus.frames_left), 240);

      // Hit coincides with the expiring tick.
      ticks(239);
      check("race_last", 32'(bus.frames_left), 1);
      bus.player_row = 9'd190;
      bus.player_col = 10'd290;
      ticks(1);
      check("race_active", 32'(bus.lightning_powerup), 1);
      check("race_pickup", 32'(bus.pickup), 1);
      check("race_frames", 32'(bus.frames_left), 180);

      // Asynchronous reset while ACTIVE, away from any clock edge.
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_lightning", 32'(bus.lightning_powerup), 0);
      check("async_rst_frames",    32'(bus.frames_left), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
